// File: rtl/vec_load_agu.sv
// vec_load_agu: vector load address generator and gather stage for LDV
// clk, rst        : rising-edge clock, synchronous active-low reset
// ldv_valid, i_in, j_in, n_in, base_in : LDV command (row, start column, dim-1, byte base)
// busy            : high while an LDV is in flight; decoder stalls on it
// mem_req, mem_addr, mem_ready, rdata : single-cycle-accept data memory read port
// vec_out, vec_valid : gathered vector (lane k at [k*W +: W]) and its one-cycle done pulse
module vec_load_agu #(
  parameter int LANES = 4,
  parameter int W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ldv_valid,
  input  logic [W-1:0]       i_in,
  input  logic [W-1:0]       j_in,
  input  logic [W-1:0]       n_in,
  input  logic [W-1:0]       base_in,
  output logic               busy,
  output logic               mem_req,
  output logic [W-1:0]       mem_addr,
  input  logic               mem_ready,
  input  logic [W-1:0]       rdata,
  output logic [LANES*W-1:0] vec_out,
  output logic               vec_valid
);
  localparam int KW = $clog2(LANES) + 1;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_nx;
  logic [KW-1:0] k, k_nx;
  logic [W-1:0] i_r, j_r, n_r, base_r, i_nx, j_nx, n_nx, base_nx, c_nx, addr_nx;
  logic accept, lane_done, last, req_nx;
  // Outputs are registered, so everything is evaluated for the lane that will be current next cycle.
  always_comb begin
    accept = state == IDLE && ldv_valid;
    lane_done = state == REQ && (!mem_req || mem_ready);
    last = k == KW'(LANES - 1);
    state_nx = accept ? REQ : state == REQ ? (lane_done && last ? DONE : REQ) : IDLE;
    k_nx = accept ? '0 : lane_done ? k + 1'b1 : k;
    i_nx = accept ? i_in : i_r;
    j_nx = accept ? j_in : j_r;
    n_nx = accept ? n_in : n_r;
    base_nx = accept ? base_in : base_r;
    c_nx = j_nx + W'(k_nx);
    req_nx = state_nx == REQ && c_nx <= n_nx;
    addr_nx = base_nx + ((i_nx * (n_nx + 1'b1) + c_nx) << 2);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      k <= '0;
      {i_r, j_r, n_r, base_r} <= '0;
      busy <= 1'b0;
      mem_req <= 1'b0;
      mem_addr <= '0;
      vec_out <= '0;
      vec_valid <= 1'b0;
    end else begin
      state <= state_nx;
      k <= k_nx;
      i_r <= i_nx;
      j_r <= j_nx;
      n_r <= n_nx;
      base_r <= base_nx;
      busy <= state_nx != IDLE;
      mem_req <= req_nx;
      mem_addr <= addr_nx;
      vec_valid <= state_nx == DONE;
      if (accept) vec_out <= '0;
      else if (state == REQ && mem_req && mem_ready) vec_out[int'(k)*W +: W] <= rdata;
    end
  end
endmodule

// File: tb/tb_vec_load_agu.sv
// tb_vec_load_agu: randomized and directed self-checking bench for vec_load_agu
module tb_vec_load_agu;
  localparam int LANES = 4;
  localparam int W = 32;
  logic clk = 0, rst = 0, ldv_valid = 0, mem_ready = 0;
  logic [W-1:0] i_in = 0, j_in = 0, n_in = 0, base_in = 0, key = 0;
  logic busy, mem_req, vec_valid;
  logic [W-1:0] mem_addr, rdata;
  logic [LANES*W-1:0] vec_out, vv_data, exp_vec;
  logic [W-1:0] hs_q[$], exp_q[$];
  int checks = 0, fails = 0, cyc = 0, stall = 0, t0 = 0;
  int vv_cyc = -1, vv_n = 0, stall_n = 0, busy_n = 0;
  bit rand_ready = 0;

  vec_load_agu #(.LANES(LANES), .W(W)) dut (
    .clk(clk), .rst(rst), .ldv_valid(ldv_valid), .i_in(i_in), .j_in(j_in), .n_in(n_in),
    .base_in(base_in), .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .rdata(rdata), .vec_out(vec_out), .vec_valid(vec_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rdata = (mem_addr >> 2) ^ key;

  always @(posedge clk) begin
    #1;
    mem_ready = stall > 0 ? 1'b0 : rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (mem_req && stall > 0) stall--;
  end

  always @(negedge clk) if (rst) begin
    if (mem_req && mem_ready) hs_q.push_back(mem_addr);
    if (mem_req && !mem_ready) stall_n++;
    if (busy) busy_n++;
    if (vec_valid) begin vv_n++; vv_cyc = cyc; vv_data = vec_out; end
  end

  function automatic void model(input logic [W-1:0] i, j, n, b);
    logic [W-1:0] col, a;
    exp_q.delete();
    exp_vec = '0;
    for (int l = 0; l < LANES; l++) begin
      col = j + W'(l);
      if (col <= n) begin
        a = b + 4 * (i * (n + 1) + col);
        exp_q.push_back(a);
        exp_vec[l*W +: W] = (a >> 2) ^ key;
      end
    end
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] i, j, n, b);
    step();
    hs_q.delete();
    vv_n = 0; stall_n = 0; busy_n = 0;
    i_in = i; j_in = j; n_in = n; base_in = b; ldv_valid = 1; t0 = cyc;
    step();
    ldv_valid = 0;
  endtask

  task automatic exec_ldv(input string nm, input logic [W-1:0] i, j, n, b, input int poke);
    bit got;
    model(i, j, n, b);
    issue(i, j, n, b);
    got = 0;
    for (int c = 1; c < 300 && !got; c++) begin
      if (vv_n > 0) got = 1;
      else begin
        if (c == poke) begin ldv_valid = 1; i_in = i + 7; end
        step();
        ldv_valid = 0;
      end
    end
    checks++;
    if (!got) begin fails++; $display("FAIL %s timeout: vec_valid not seen within 300 cycles", nm); end
    else begin
      checks++;
      if (vv_data !== exp_vec) begin fails++; $display("FAIL %s vec_out: got %h expected %h", nm, vv_data, exp_vec); end
      checks++;
      if (vv_cyc !== t0 + LANES + 1 + stall_n) begin
        fails++; $display("FAIL %s latency: vec_valid at %0d expected %0d", nm, vv_cyc - t0, LANES + 1 + stall_n);
      end
      checks++;
      if (busy_n !== vv_cyc - t0) begin fails++; $display("FAIL %s busy: %0d busy cycles expected %0d", nm, busy_n, vv_cyc - t0); end
      checks++;
      if (hs_q.size() !== exp_q.size()) begin
        fails++; $display("FAIL %s request count: got %0d expected %0d", nm, hs_q.size(), exp_q.size());
      end else foreach (exp_q[x]) begin
        checks++;
        if (hs_q[x] !== exp_q[x]) begin fails++; $display("FAIL %s addr[%0d]: got %h expected %h", nm, x, hs_q[x], exp_q[x]); end
      end
      step();
      checks++;
      if (vec_valid !== 1'b0 || busy !== 1'b0 || vec_out !== exp_vec) begin
        fails++; $display("FAIL %s after done: vec_valid=%b busy=%b vec_out=%h expected 0 0 %h", nm, vec_valid, busy, vec_out, exp_vec);
      end
    end
  endtask

  task automatic test_reset();
    rst = 0;
    ldv_valid = 1; i_in = $urandom; j_in = 0; n_in = 3; base_in = $urandom;
    repeat (3) step();
    ldv_valid = 0;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b expected 0", busy); end
    checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset mem_req: got %b expected 0", mem_req); end
    checks++; if (mem_addr !== '0) begin fails++; $display("FAIL reset mem_addr: got %h expected 0", mem_addr); end
    checks++; if (vec_out !== '0) begin fails++; $display("FAIL reset vec_out: got %h expected 0", vec_out); end
    checks++; if (vec_valid !== 1'b0) begin fails++; $display("FAIL reset vec_valid: got %b expected 0", vec_valid); end
    rst = 1;
  endtask

  task automatic test_basic();
    exec_ldv("basic", 1, 0, 3, 32'h100, 0);
    checks++;
    if (vv_data !== {32'h47, 32'h46, 32'h45, 32'h44}) begin fails++; $display("FAIL basic lanes: got %h expected 47/46/45/44", vv_data); end
  endtask

  task automatic test_partial();
    exec_ldv("partial", 1, 2, 3, 32'h100, 0);
    checks++;
    if (vv_data !== {32'h0, 32'h0, 32'h47, 32'h46}) begin fails++; $display("FAIL partial lanes: got %h expected 0/0/47/46", vv_data); end
  endtask

  task automatic test_wait();
    stall = 3;
    exec_ldv("wait", 1, 0, 3, 32'h100, 0);
    checks++;
    if (stall_n !== 3 || vv_cyc !== t0 + 8) begin
      fails++; $display("FAIL wait: stalls %0d latency %0d expected 3 and 8", stall_n, vv_cyc - t0);
    end
  endtask

  task automatic test_ignore();
    exec_ldv("ignore_ldv", 1, 0, 3, 32'h100, 2);
  endtask

  task automatic test_mid_reset();
    issue(1, 0, 3, 32'h100);
    for (int c = 0; c < 50 && hs_q.size() < 2; c++) step();
    checks++;
    if (hs_q.size() !== 2) begin fails++; $display("FAIL mid_reset setup: %0d lanes captured expected 2", hs_q.size()); end
    rst = 0;
    step();
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || vec_out !== '0 || vec_valid !== 1'b0) begin
      fails++; $display("FAIL mid_reset state: busy=%b mem_req=%b vec_out=%h vec_valid=%b expected all 0", busy, mem_req, vec_out, vec_valid);
    end
    rst = 1;
    exec_ldv("after_reset", 2, 1, 3, 32'h200, 0);
  endtask

  task automatic test_boundaries();
    exec_ldv("n_zero", 5, 0, 0, 32'h40, 0);
    exec_ldv("j_gt_n", 1, 5, 3, 32'h100, 0);
    checks++;
    if (vv_data !== '0) begin fails++; $display("FAIL j_gt_n lanes: got %h expected 0", vv_data); end
    exec_ldv("i_gt_n", 9, 1, 2, 32'h1000, 0);
  endtask

  task automatic test_wrap();
    exec_ldv("wrap", 0, 0, 3, 32'hFFFF_FFF8, 0);
    checks++;
    if (hs_q.size() !== 4 || hs_q[2] !== 32'h0 || hs_q[3] !== 32'h4) begin
      fails++; $display("FAIL wrap addresses: %0d requests, lanes 2/3 at %h %h expected 0 4", hs_q.size(), hs_q[2], hs_q[3]);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] i, j, n, b;
    rand_ready = 1;
    for (int r = 0; r < 24; r++) begin
      key = $urandom;
      n = $urandom_range(0, 6);
      j = $urandom_range(0, 32'(n) + 2);
      if (r % 6 == 5) begin n = 32'hFFFF_FFFF; j = 32'hFFFF_FFFE; end
      i = $urandom_range(0, 9);
      b = $urandom & 32'hFFFF_FFFC;
      exec_ldv($sformatf("random%0d", r), i, j, n, b, $urandom_range(0, 3));
    end
    rand_ready = 0;
    key = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_wait();
    test_ignore();
    test_mid_reset();
    test_boundaries();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/vec_load_agu.md
Name: vec_load_agu

Overview:
- Vector load address generator and gather stage.
- Sits directly downstream of the decode-stage scalar register file and consumes its i/j/n outputs when an LDV is decoded.
- Fetches up to LANES consecutive 32-bit words of row i of a square matrix with dimension n+1, starting at column j, from data memory.
- Presents the assembled vector to the execute stage with a one-cycle valid pulse.

Parameters:
LANES, 4, number of vector lanes (elements fetched per LDV); valid range 1..16
W, 32, element/address width in bits

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-low reset (rst==0 at a rising edge resets)
ldv_valid  input  1  LDV decoded this cycle; i_in/j_in/n_in/base_in are valid
i_in  input  W  row index i
j_in  input  W  start column j
n_in  input  W  matrix dimension minus one (n)
base_in  input  W  byte base address of matrix
busy  output  1  block is processing an LDV; decoder must stall
mem_req  output  1  read request to data memory
mem_addr  output  W  byte address of current request
mem_ready  input  1  memory accepts request; rdata valid the same cycle
rdata  input  W  read data
vec_out  output  LANES*W  assembled vector; lane k at bits [k*W +: W]
vec_valid  output  1  one-cycle pulse: vec_out is complete

Behaviour:
- Reset (rst==0 at posedge, regardless of state):
  - FSM goes to IDLE; lane counter k=0.
  - busy=0, mem_req=0, mem_addr=0, vec_out=0, vec_valid=0.
  - Any in-flight request is abandoned; a mem_ready arriving the same cycle is ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - busy=0, mem_req=0.
  - If ldv_valid, latch i, j, n, base; clear vec_out to 0; set k=0; go to REQ.
  - busy rises the cycle after ldv_valid.
- REQ:
  - busy=1.
  - Column c = j+k (W-bit, wrapping).
  - In-range lane (c <= n, unsigned):
    - mem_req=1, mem_addr = base + ((i*(n+1) + c) << 2).
    - All arithmetic is W-bit, truncated modulo 2^W.
    - mem_req and mem_addr stay stable until a cycle with mem_ready=1.
    - On that cycle, lane k takes rdata and k increments.
  - Out-of-range lane (c > n):
    - No request (mem_req=0); lane k is left as 0.
    - k increments in one cycle.
  - When the lane just completed is k=LANES-1, go to DONE.
- DONE:
  - vec_valid=1 for exactly one cycle; busy=1; mem_req=0.
  - Next state is IDLE.
- vec_out holds its value from the DONE cycle until the next accepted ldv_valid.
- ldv_valid while busy=1 (REQ or DONE) is ignored. There is no queue.
- Latency with zero memory wait states and all lanes in range:
  - ldv_valid at cycle t, first mem_req at t+1, vec_valid at t+LANES+1.
  - Each memory wait state adds one cycle.
- Boundaries:
  - n=0: only column 0 is valid. With j=0, one request is made and the other lanes are 0.
  - j > n: no requests; vec_valid fires at t+LANES+1 with vec_out=0.
  - i > n: not checked. The address is computed as specified.
  - Address overflow wraps modulo 2^W.
  - mem_ready while mem_req=0 is ignored.

Test Plan:
- LANES=4, base=0x100, i=1, j=0, n=3, zero-wait memory returning addr>>2 as data -> addresses 0x110, 0x114, 0x118, 0x11C on consecutive cycles; vec_valid 5 cycles after ldv_valid; vec_out lanes = {0x44, 0x45, 0x46, 0x47}.
- Same setup, j=2 -> two requests (0x118, 0x11C); lanes = {0x46, 0x47, 0, 0}; vec_valid at t+5.
- mem_ready held low 3 cycles on the first request -> mem_addr stays 0x110 and mem_req stays 1 for 4 cycles; vec_valid at t+8; data unchanged.
- ldv_valid pulsed again during REQ with different i -> ignored; result matches the first command; busy continuous until after vec_valid.
- rst=0 mid-REQ after 2 lanes captured -> next cycle busy=0, mem_req=0, vec_out=0, vec_valid=0; a new LDV completes normally.
- base=0xFFFFFFF8, i=0, j=0, n=3 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 (wrap).
